// File: rtl/game_flow_controller.sv
// Game flow sequencer: IDLE/PLAY/DYING/GAME_OVER with frame-tick consumption of collision flags.
// Optional feature: define GAME_FLOW_BONUS_LIFE_EN to award a life each time score crosses a BONUS_SCORE step.
module game_flow_controller #(
    parameter int unsigned INIT_LIVES     = 3,
    parameter int unsigned MAX_LIVES      = 7,
    parameter int unsigned RESPAWN_FRAMES = 60,
    parameter int unsigned GOLD_POINTS    = 500,
    parameter int unsigned ALIEN_POINTS   = 250,
    parameter int unsigned BONUS_SCORE    = 20000
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        start_key,
    input  logic        player_died,
    input  logic        alien_died_a,
    input  logic        player_eat_gold_1,
    output logic [1:0]  game_state,
    output logic        player_awake,
    output logic [2:0]  lives,
    output logic [15:0] score,
    output logic        respawn,
    output logic        level_start
);

    localparam int unsigned SCORE_W     = 16;
    localparam int unsigned LIVES_W     = 3;
    localparam int unsigned CNT_W       = 8;
    // Wide enough for a saturated score plus any single increment, and for the bonus threshold.
    localparam int unsigned SUM_W       = $clog2(65536 + GOLD_POINTS + ALIEN_POINTS + BONUS_SCORE + 1);
    localparam int unsigned START_LIVES = (INIT_LIVES > MAX_LIVES) ? MAX_LIVES : INIT_LIVES;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DYING = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t             r_state,        w_state_nx;
    logic [CNT_W-1:0]   r_cnt,          w_cnt_nx;
    logic [LIVES_W-1:0] r_lives,        w_lives_nx;
    logic [SCORE_W-1:0] r_score,        w_score_nx;
    logic               r_flag_died,    w_flag_died_nx;
    logic               r_flag_alien,   w_flag_alien_nx;
    logic               r_flag_gold,    w_flag_gold_nx;
    logic               r_key_block,    w_key_block_nx;
    logic               r_awake,        w_awake_nx;
    logic               r_respawn,      w_respawn_nx;
    logic               r_level_start,  w_level_start_nx;

    logic [SUM_W-1:0]   w_sum;
    logic [SCORE_W-1:0] w_score_add;
    logic [LIVES_W:0]   w_lives_gain;
    logic [LIVES_W:0]   w_lives_net;

    // Score credit for the frame being closed, saturating at the 16-bit ceiling.
    assign w_sum = SUM_W'(r_score)
                 + (r_flag_gold  ? SUM_W'(GOLD_POINTS)  : SUM_W'(0))
                 + (r_flag_alien ? SUM_W'(ALIEN_POINTS) : SUM_W'(0));
    assign w_score_add = (w_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : w_sum[SCORE_W-1:0];

`ifdef GAME_FLOW_BONUS_LIFE_EN
    logic [SUM_W-1:0]   r_next_bonus,   w_next_bonus_nx;
    logic               w_bonus;
    logic [LIVES_W:0]   w_lives_plus;

    assign w_bonus      = (SUM_W'(w_score_add) >= r_next_bonus);
    assign w_lives_plus = {1'b0, r_lives} + (w_bonus ? (LIVES_W+1)'(1) : (LIVES_W+1)'(0));
    assign w_lives_gain = (w_lives_plus > (LIVES_W+1)'(MAX_LIVES)) ? (LIVES_W+1)'(MAX_LIVES)
                                                                  : w_lives_plus;
`else
    assign w_lives_gain = {1'b0, r_lives};
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_lives       <= LIVES_W'(START_LIVES);
            r_score       <= '0;
            r_flag_died   <= 1'b0;
            r_flag_alien  <= 1'b0;
            r_flag_gold   <= 1'b0;
            r_key_block   <= 1'b0;
            r_awake       <= 1'b0;
            r_respawn     <= 1'b0;
            r_level_start <= 1'b0;
`ifdef GAME_FLOW_BONUS_LIFE_EN
            r_next_bonus  <= SUM_W'(BONUS_SCORE);
`endif
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_lives       <= w_lives_nx;
            r_score       <= w_score_nx;
            r_flag_died   <= w_flag_died_nx;
            r_flag_alien  <= w_flag_alien_nx;
            r_flag_gold   <= w_flag_gold_nx;
            r_key_block   <= w_key_block_nx;
            r_awake       <= w_awake_nx;
            r_respawn     <= w_respawn_nx;
            r_level_start <= w_level_start_nx;
`ifdef GAME_FLOW_BONUS_LIFE_EN
            r_next_bonus  <= w_next_bonus_nx;
`endif
        end
    end

    // Next-state, flag and output logic.
    always_comb begin
        w_state_nx       = r_state;
        w_cnt_nx         = r_cnt;
        w_lives_nx       = r_lives;
        w_score_nx       = r_score;
        w_key_block_nx   = r_key_block & start_key;
        w_respawn_nx     = 1'b0;
        w_level_start_nx = 1'b0;
        w_lives_net      = w_lives_gain;
        w_flag_died_nx   = 1'b0;
        w_flag_alien_nx  = 1'b0;
        w_flag_gold_nx   = 1'b0;
`ifdef GAME_FLOW_BONUS_LIFE_EN
        w_next_bonus_nx  = r_next_bonus;
`endif

        // A tick consumes the flags; inputs seen on the tick itself start the next frame.
        if (r_state == S_PLAY) begin
            w_flag_died_nx  = player_died       | (r_flag_died  & ~startOfFrame);
            w_flag_alien_nx = alien_died_a      | (r_flag_alien & ~startOfFrame);
            w_flag_gold_nx  = player_eat_gold_1 | (r_flag_gold  & ~startOfFrame);
        end

        case (r_state)
            S_IDLE: begin
                w_lives_nx = LIVES_W'(START_LIVES);
                w_score_nx = '0;
                w_cnt_nx   = '0;
`ifdef GAME_FLOW_BONUS_LIFE_EN
                w_next_bonus_nx = SUM_W'(BONUS_SCORE);
`endif
                if (start_key && !r_key_block) begin
                    w_state_nx       = S_PLAY;
                    w_level_start_nx = 1'b1;
                end
            end
            S_PLAY: begin
                if (startOfFrame) begin
                    w_score_nx = w_score_add;
`ifdef GAME_FLOW_BONUS_LIFE_EN
                    if (w_bonus) begin
                        w_next_bonus_nx = r_next_bonus + SUM_W'(BONUS_SCORE);
                    end
`endif
                    if (r_flag_died) begin
                        w_lives_net = w_lives_gain - (LIVES_W+1)'(1);
                        if (w_lives_net == '0) begin
                            w_state_nx = S_OVER;
                        end else begin
                            w_state_nx = S_DYING;
                            w_cnt_nx   = CNT_W'(RESPAWN_FRAMES);
                        end
                    end
                    w_lives_nx = w_lives_net[LIVES_W-1:0];
                end
            end
            S_DYING: begin
                if (startOfFrame) begin
                    if (r_cnt <= CNT_W'(1)) begin
                        w_state_nx   = S_PLAY;
                        w_cnt_nx     = '0;
                        w_respawn_nx = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt - CNT_W'(1);
                    end
                end
            end
            S_OVER: begin
                // Held key must be released before IDLE will accept a new start.
                if (start_key) begin
                    w_state_nx     = S_IDLE;
                    w_key_block_nx = 1'b1;
                    w_lives_nx     = LIVES_W'(START_LIVES);
                    w_score_nx     = '0;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        w_awake_nx = (w_state_nx == S_PLAY);
    end

    assign game_state   = r_state;
    assign player_awake = r_awake;
    assign lives        = r_lives;
    assign score        = r_score;
    assign respawn      = r_respawn;
    assign level_start  = r_level_start;

endmodule
